// File: rtl/mdr_mem_port.sv
// Memory data register: loads from the internal bus or runs a byte/half/word read/write against a ready-based memory.
// Latency: request registered on the accept edge; completion (Q update, Done) on the edge that samples mem_ready=1.
// Backpressure: waits indefinitely on mem_ready unless TIMEOUT_CYCLES>0, then aborts with Error; Read/Write/MDRin ignored while busy.
module mdr_mem_port #(
    parameter  int DATA_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 15,
    localparam int OFF_W          = $clog2(DATA_WIDTH / 8)
) (
    input  logic                    Clock,
    input  logic                    Clear,
    input  logic                    MDRin,
    input  logic                    Read,
    input  logic                    Write,
    input  logic [1:0]              Size,
    input  logic                    Unsigned,
    input  logic [OFF_W-1:0]        ByteOffset,
    input  logic [DATA_WIDTH-1:0]   BusMuxOut,
    output logic [DATA_WIDTH-1:0]   Q,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Error
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   q_q, q_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           be_q, be_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [OFF_W-1:0]        off_q, off_d;

    logic [NB-1:0]           lane_mask;
    logic [DATA_WIDTH-1:0]   store_dat;
    logic                    bad_req;
    logic [DATA_WIDTH-1:0]   rd_shift;
    logic [DATA_WIDTH-1:0]   load_dat;
    logic [TW-1:0]           timer_inc;

    // Issue-side decode: lane mask, aligned store data and alignment check from live inputs
    always_comb begin
        lane_mask = '0;
        store_dat = '0;
        bad_req   = 1'b0;
        case (Size)
            2'b00: begin
                lane_mask = NB'(1) << ByteOffset;
                store_dat = DATA_WIDTH'(q_q[7:0]) << {ByteOffset, 3'b000};
                bad_req   = (int'(ByteOffset) >= NB);
            end
            2'b01: begin
                lane_mask = NB'(3) << ByteOffset;
                store_dat = DATA_WIDTH'(q_q[15:0]) << {ByteOffset, 3'b000};
                bad_req   = ByteOffset[0] || (int'(ByteOffset) + 2 > NB);
            end
            2'b10: begin
                lane_mask = '1;
                store_dat = q_q;
                bad_req   = (ByteOffset != '0);
            end
            default: bad_req = 1'b1;
        endcase
    end

    // Load-side extract: shift the addressed lane down and extend it using the attributes captured at issue
    always_comb begin
        rd_shift = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_dat = uns_q ? DATA_WIDTH'(rd_shift[7:0])
                                      : {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_dat = uns_q ? DATA_WIDTH'(rd_shift[15:0])
                                      : {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
            default: load_dat = mem_rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        req_d     = req_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        timer_d   = timer_q;
        size_d    = size_q;
        uns_d     = uns_q;
        off_d     = off_q;
        timer_inc = timer_q + TW'(1);
        case (state_q)
            IDLE: begin
                if (Read && Write) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end else if ((Read || Write) && bad_req) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end else if (Read || Write) begin
                    req_d   = 1'b1;
                    we_d    = Write;
                    be_d    = lane_mask;
                    wdata_d = Write ? store_dat : '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    timer_d = '0;
                    size_d  = Size;
                    uns_d   = Unsigned;
                    off_d   = ByteOffset;
                    state_d = Write ? WR_WAIT : RD_WAIT;
                end else if (MDRin) begin
                    q_d = BusMuxOut;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ready || (TIMEOUT_CYCLES > 0 && timer_inc == TO_VAL)) begin
                    if (mem_ready && state_q == RD_WAIT) begin
                        q_d = load_dat;
                    end
                    if (!mem_ready) begin
                        err_d = 1'b1;
                    end
                    req_d   = 1'b0;
                    be_d    = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; asynchronous clear aborts any pending request immediately
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= IDLE;
            q_q     <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            req_q   <= req_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
        end
    end

    assign Q         = q_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Error     = err_q;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed bench for mdr_mem_port: reset/load, reads, writes, error cases, timeout and async clear mid-read.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: mem_ready is driven by hand to model wait states.
module tb_mdr_mem_port;

    logic        Clock;
    logic        Clear;
    logic        MDRin;
    logic        Read;
    logic        Write;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [1:0]  ByteOffset;
    logic [31:0] BusMuxOut;
    logic [31:0] Q;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        Busy;
    logic        Done;
    logic        Error;

    int n_cmp = 0;
    int n_err = 0;

    mdr_mem_port #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(15)) dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .MDRin      (MDRin),
        .Read       (Read),
        .Write      (Write),
        .Size       (Size),
        .Unsigned   (Unsigned),
        .ByteOffset (ByteOffset),
        .BusMuxOut  (BusMuxOut),
        .Q          (Q),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Packs {mem_req, mem_we, Busy, Done, Error, mem_be} for compact control checks
    function automatic logic [31:0] ctl();
        return {23'b0, mem_req, mem_we, Busy, Done, Error, mem_be};
    endfunction

    initial begin
        Clear = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
        Size = 2'b00; Unsigned = 1'b0; ByteOffset = 2'd0;
        BusMuxOut = '0; mem_rdata = '0; mem_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_q",     Q,         32'h0);
        chk("rst_ctl",   ctl(),     32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);

        // Bus load
        Clear = 1'b1; MDRin = 1'b1; BusMuxOut = 32'hDEADBEEF;
        tick();
        MDRin = 1'b0;
        chk("load_q",    Q,    32'hDEADBEEF);
        chk("load_busy", {31'b0, Busy}, 32'h0);

        // Signed byte read, offset 2, ready on third wait edge
        Read = 1'b1; Size = 2'b00; ByteOffset = 2'd2; Unsigned = 1'b0;
        mem_rdata = 32'h12F45678;
        tick();
        Read = 1'b0;
        chk("sb_issue", ctl(), {23'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100});
        tick();
        chk("sb_wait1", ctl(), {23'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100});
        tick();
        chk("sb_wait2_q", Q, 32'hDEADBEEF);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("sb_q",    Q,     32'hFFFFFFF4);
        chk("sb_done", ctl(), {23'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000});
        tick();
        chk("sb_done_drop", {31'b0, Done}, 32'h0);

        // Unsigned halfword read, zero-wait; changed attributes after issue must not matter
        Read = 1'b1; Size = 2'b01; ByteOffset = 2'd2; Unsigned = 1'b1;
        mem_rdata = 32'h8001ABCD;
        tick();
        Read = 1'b0; Size = 2'b00; ByteOffset = 2'd0; Unsigned = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("uh_q",    Q,     32'h00008001);
        chk("uh_done", {31'b0, Done}, 32'h1);

        // Byte write at offset 3; MDRin during the wait is ignored
        MDRin = 1'b1; BusMuxOut = 32'h000000A5;
        tick();
        MDRin = 1'b0;
        Write = 1'b1; Size = 2'b00; ByteOffset = 2'd3;
        tick();
        Write = 1'b0; MDRin = 1'b1; BusMuxOut = 32'h11111111;
        chk("bw_ctl",   ctl(),     {23'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000});
        chk("bw_wdata", mem_wdata, 32'hA5000000);
        tick(); tick();
        chk("bw_hold_ctl",   ctl(),     {23'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000});
        chk("bw_hold_wdata", mem_wdata, 32'hA5000000);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; MDRin = 1'b0;
        chk("bw_q",    Q,     32'h000000A5);
        chk("bw_done", {29'b0, mem_req, Busy, Done}, 32'h1);

        // Misaligned halfword read
        Read = 1'b1; Size = 2'b01; ByteOffset = 2'd1;
        tick();
        Read = 1'b0;
        chk("mis_ctl", {29'b0, mem_req, Done, Error}, 32'h3);
        tick();
        chk("mis_sticky", {29'b0, mem_req, Done, Error}, 32'h1);

        // Valid word read clears Error
        Read = 1'b1; Size = 2'b10; ByteOffset = 2'd0; mem_rdata = 32'hCAFEF00D;
        tick();
        Read = 1'b0;
        chk("wr_clr_err", {30'b0, mem_req, Error}, 32'h2);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("wr_q", Q, 32'hCAFEF00D);

        // Read and Write together
        Read = 1'b1; Write = 1'b1; Size = 2'b10; ByteOffset = 2'd0;
        tick();
        Read = 1'b0; Write = 1'b0;
        chk("rw_ctl", {29'b0, mem_req, Done, Error}, 32'h3);
        chk("rw_q",   Q, 32'hCAFEF00D);
        tick();

        // Reserved size
        Write = 1'b1; Size = 2'b11;
        tick();
        Write = 1'b0;
        chk("rsv_ctl", {29'b0, mem_req, Done, Error}, 32'h3);
        tick();

        // Timeout: ready never arrives, abort on the 15th wait edge
        Read = 1'b1; Size = 2'b10; ByteOffset = 2'd0; mem_rdata = 32'h55555555;
        tick();
        Read = 1'b0;
        chk("to_issue", {29'b0, mem_req, Busy, Error}, 32'h6);
        repeat (14) tick();
        chk("to_pending", {28'b0, mem_req, Busy, Done, Error}, 32'hC);
        tick();
        chk("to_abort", {28'b0, mem_req, Busy, Done, Error}, 32'h3);
        chk("to_be",    {28'b0, mem_be}, 32'h0);
        chk("to_q",     Q, 32'hCAFEF00D);
        tick();

        // Async clear while waiting on a read; late ready afterwards is ignored
        Read = 1'b1; Size = 2'b10; ByteOffset = 2'd0; mem_rdata = 32'h77777777;
        tick();
        Read = 1'b0;
        chk("ar_issue", {31'b0, mem_req}, 32'h1);
        #2 Clear = 1'b0;
        #1;
        chk("ar_drop", {29'b0, mem_req, Busy, Done}, 32'h0);
        chk("ar_q",    Q, 32'h0);
        tick();
        Clear = 1'b1; mem_ready = 1'b1;
        tick();
        chk("ar_late_q",   Q, 32'h0);
        chk("ar_late_ctl", ctl(), 32'h0);
        mem_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdr_mem_port.md
Name: mdr_mem_port

Overview:
Parametrised memory data register that adds a memory-side handshake to the CPU's MDR. It loads from the internal bus, or runs a byte/halfword/word read or write against a ready-based memory. On reads it extracts the addressed lane and sign- or zero-extends it. On writes it aligns data and generates byte enables. It sits between the datapath bus (BusMuxOut/MDRout) and the memory subsystem, and replaces the plain bus/memory-mux register.

Parameters:
DATA_WIDTH, 32, register/memory data width; multiple of 8, minimum 16.
TIMEOUT_CYCLES, 15, wait cycles before a memory op is aborted; 0 disables the timeout.
OFF_W, $clog2(DATA_WIDTH/8), byte-offset width (derived, not overridden).

Ports:
Clock  in  1  system clock, rising edge.
Clear  in  1  asynchronous, active-low reset.
MDRin  in  1  load Q from BusMuxOut (honoured only in IDLE).
Read  in  1  start memory read (sampled in IDLE).
Write  in  1  start memory write of Q (sampled in IDLE).
Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
Unsigned  in  1  1 zero-extends sub-word loads; 0 sign-extends.
ByteOffset  in  OFF_W  byte lane within the word.
BusMuxOut  in  DATA_WIDTH  internal bus data.
Q  out  DATA_WIDTH  MDR contents to bus.
mem_rdata  in  DATA_WIDTH  memory read data, valid when mem_ready=1.
mem_ready  in  1  memory completes current request.
mem_req  out  1  request active.
mem_we  out  1  1 write, 0 read; valid while mem_req=1.
mem_wdata  out  DATA_WIDTH  lane-aligned write data.
mem_be  out  DATA_WIDTH/8  byte enables.
Busy  out  1  high in RD_WAIT/WR_WAIT.
Done  out  1  one-cycle pulse on operation completion or abort.
Error  out  1  sticky; cleared when the next Read/Write is accepted.

Behaviour:
- Reset (Clear=0, asynchronous): all outputs 0, state IDLE, timer 0. Reset mid-operation aborts the operation; mem_req drops without waiting for a clock.
- States: IDLE, RD_WAIT, WR_WAIT. All outputs are registered.
- IDLE, decision order on each edge:
  - Read and Write both high: Error<=1, Done<=1, no request.
  - Read or Write with Size=11, halfword at an odd offset, or word at a non-zero offset: Error<=1, Done<=1, no request.
  - Valid Read: mem_req<=1, mem_we<=0, mem_be<=lane mask, Error<=0, Busy<=1, go to RD_WAIT.
  - Valid Write: mem_req<=1, mem_we<=1, mem_wdata/mem_be per the store rule, Error<=0, Busy<=1, go to WR_WAIT.
  - Otherwise, MDRin=1: Q<=BusMuxOut.
  - Read/Write take priority over MDRin in the same cycle.
- Lane mask: byte gives a one-hot at ByteOffset. Halfword gives two bits starting at ByteOffset. Word gives all ones.
- Store rule: byte places Q[7:0] at bits 8*ByteOffset; halfword places Q[15:0] at 8*ByteOffset; word places Q. Unused lanes are 0.
- RD_WAIT/WR_WAIT:
  - mem_req, mem_we, mem_be and mem_wdata are held stable.
  - MDRin, Read and Write are ignored.
  - Timer increments every cycle that mem_ready=0.
- Completion (mem_ready=1 at an edge):
  - Read only: Q<=extended lane data. The lane is mem_rdata[8*ByteOffset +: 8 or 16], or the full word; Size/Unsigned/ByteOffset are captured at issue.
  - Read and write: mem_req<=0, mem_be<=0, Busy<=0, Done<=1 for exactly one cycle, back to IDLE.
- Timeout: when the timer reaches TIMEOUT_CYCLES (non-zero) with no ready, apply the completion actions except Q is unchanged, and set Error<=1.
- Timer resets to 0 on every accept.
- Latency:
  - Read sampled at edge 0 → mem_req high after edge 0.
  - With ready at edge 1, Q is updated and Done is high after edge 1.
  - A new op can be accepted at edge 2; back-to-back throughput is one op per 2 cycles minimum.
- mem_ready while in IDLE is ignored.

Test Plan:
- Reset/load: Clear=0 with all outputs checked at 0. Release, MDRin=1, BusMuxOut=0xDEADBEEF → Q=0xDEADBEEF after 1 edge; Busy=0.
- Signed byte read: Read, Size=00, Offset=2, Unsigned=0, mem_rdata=0x12F45678, ready 3 cycles later → mem_be=0100 during request; Q=0xFFFFFFF4; Done pulses once; Error=0.
- Unsigned halfword read with zero-wait: Size=01, Offset=2, Unsigned=1, mem_rdata=0x8001ABCD, ready at first wait edge → Q=0x00008001 two edges after Read.
- Byte write: Q=0x000000A5, Write, Size=00, Offset=3 → mem_we=1, mem_wdata=0xA5000000, mem_be=1000, held until ready; Q unchanged.
- Errors: Size=01/Offset=1, Read&Write together, and Size=11 → Error=1, Done pulse, mem_req never asserted. Timeout: ready held low → mem_req drops, Error=1 after 15 wait cycles, Q unchanged. Next valid Read clears Error.
- Reset mid-read: Clear=0 asynchronously while in RD_WAIT → mem_req/Busy=0 immediately, Q=0. A late mem_ready after release is ignored.
